edge_detect: RTL and testbench
==============================

Name: edge_detect

Overview:
- Frame-memory edge-detection engine.
- Reads a 24-bit RGB image starting at addr_in, computes a Sobel gradient magnitude of each pixel's grayscale value, and writes a grey RGB result image starting at addr_out.
- Sits between the BMP loader/writer and the shared frame memory as a single memory master, controlled by a level start/done handshake.

Parameters:
- AW, 32, memory address width (word address).
- DW, 32, memory data width; pixel occupies bits [23:0] as {R[23:16],G[15:8],B[7:0]}, bits [31:24] written 0.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- addr_in  in  AW  word address of source pixel (0,0).
- addr_out  in  AW  word address of destination pixel (0,0).
- width  in  32  image width in pixels.
- height  in  32  image height in pixels.
- start  in  1  level request; sampled only in IDLE.
- done  out  1  high from job completion until start is low.
- mem_addr  out  AW  memory word address.
- mem_rd  out  1  read strobe; one word per cycle asserted.
- mem_rdata  in  DW  read data, valid exactly 1 cycle after mem_rd.
- mem_wr  out  1  write strobe; one word per cycle asserted.
- mem_wdata  out  DW  write data.

Behaviour:
- Reset: done=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, FSM=IDLE; applies immediately, including mid-job (job abandoned, no further accesses).
- Addressing: pixel (x,y) is at base + y*width + x, row-major, y=0 first; widths up to 32 bits, modulo 2^AW.
- FSM IDLE -> LOAD when start=1 and done=0; x,y cleared.
- Empty image: if width=0 or height=0, go straight to DONE with no memory accesses.
- Border pixels: if x=0, y=0, x=width-1 or y=height-1, skip LOAD/CALC and WRITE 0.
- LOAD: issue 9 reads of the 3x3 neighbourhood p0..p8, row-major from (x-1,y-1), one per cycle. Capture each on the following cycle.
- Gray conversion per neighbour: g = (R + 2G + B) >> 2, 8 bits.
- CALC, one cycle:
  - Gx = (p2+2p5+p8) - (p0+2p3+p6), signed 12-bit.
  - Gy = (p6+2p7+p8) - (p0+2p1+p2), signed 12-bit.
  - m = |Gx| + |Gy|, saturated to 255.
- WRITE: single mem_wr cycle at addr_out + y*width + x, data {8'h00, m, m, m}.
- NEXT: x++, wrap at width to 0 with y++. After pixel (width-1, height-1) -> DONE.
- Access rules: mem_rd and mem_wr are never high in the same cycle. Processing order is strictly raster.
- DONE: done=1 is held while start=1. When start=0, done drops on the next cycle and FSM returns to IDLE.
- A new job requires start low then high again.
- start falling during a job is ignored; the job completes and done pulses for at least one cycle.
- width or height < 3: all pixels are border; output image is all zero.
- Inputs addr_in, addr_out, width and height are captured at job start. Later changes have no effect on the running job.
- Overlapping source/destination regions: behaviour undefined (caller's responsibility).

Test Plan:
- 4x4 uniform image, all 0x808080, addr_in=0, addr_out=100 -> 16 writes to 100..115, all 0x000000; done=1; done falls 1 cycle after start low.
- 3x3 image, columns 0/0/255 gray (0x000000, 0x000000, 0xFFFFFF) -> word addr_out+4 = 0x00FFFFFF (Gx=1020, saturated); the other 8 words = 0.
- 3x3 image, right column 0x101010, rest 0 -> centre = 0x00404040 (Gx=64, Gy=0); borders 0.
- width=0, height=5, start=1 -> done=1 within 3 cycles; mem_rd and mem_wr never asserted.
- Reset mid-LOAD (reset_n low 1 cycle during 640x480 job) -> outputs 0 immediately; no accesses afterwards; start still high begins a fresh job.
- Handshake: start held high after done -> done stays 1 and no new job starts; start low then high -> second identical job produces identical memory contents.

Source files
------------

// File: rtl/edge_detect.sv
// Sobel edge-detection engine: reads a 24-bit RGB frame from word memory and
// writes a grey gradient-magnitude frame, one pixel at a time in raster order.
module edge_detect #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] addr_in,
  input  logic [AW-1:0] addr_out,
  input  logic [31:0]   width,
  input  logic [31:0]   height,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DISPATCH = 3'd1,
    S_LOAD     = 3'd2,
    S_CALC     = 3'd3,
    S_WRITE    = 3'd4,
    S_NEXT     = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] TWO_A = {{(AW-2){1'b0}}, 2'd2};

  function automatic logic [7:0] gray_of(input logic [23:0] px);
    logic [9:0] s;
    s = {2'b00, px[23:16]} + {1'b0, px[15:8], 1'b0} + {2'b00, px[7:0]};
    return s[9:2];
  endfunction

  function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  state_t        state_r;
  logic [AW-1:0] ain_r, aout_r, off_r;
  logic [31:0]   width_r, height_r, x_r, y_r;
  logic [3:0]    rd_cnt_r, cap_cnt_r;
  logic [1:0]    col_r;
  logic          cap_pend_r;
  logic [7:0]    win_r [0:8];
  logic          done_r, mem_rd_r, mem_wr_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r;

  logic [AW-1:0]       wid_a_s, rd_first_s;
  logic                border_s, last_col_s, last_row_s, empty_s;
  logic signed [11:0]  gx_s, gy_s;
  logic [11:0]         ax_s, ay_s, mag_s;
  logic [7:0]          m_s;
  logic                unused_ok_s;

  assign unused_ok_s = ^{mem_rdata[DW-1:24]};

  // Pixel position, addressing and Sobel arithmetic on the captured window.
  always_comb begin
    wid_a_s    = AW'(width_r);
    rd_first_s = ain_r + off_r - wid_a_s - ONE_A;
    empty_s    = (width_r == 32'd0) || (height_r == 32'd0);
    last_col_s = (x_r == width_r - 32'd1);
    last_row_s = (y_r == height_r - 32'd1);
    border_s   = (x_r == 32'd0) || (y_r == 32'd0) || last_col_s || last_row_s;
    gx_s  = $signed({2'b00, wsum(win_r[2], win_r[5], win_r[8])})
          - $signed({2'b00, wsum(win_r[0], win_r[3], win_r[6])});
    gy_s  = $signed({2'b00, wsum(win_r[6], win_r[7], win_r[8])})
          - $signed({2'b00, wsum(win_r[0], win_r[1], win_r[2])});
    ax_s  = gx_s[11] ? $unsigned(-gx_s) : $unsigned(gx_s);
    ay_s  = gy_s[11] ? $unsigned(-gy_s) : $unsigned(gy_s);
    mag_s = ax_s + ay_s;
    m_s   = (mag_s > 12'd255) ? 8'hFF : mag_s[7:0];
  end

  // Job sequencer with registered memory strobes and done flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      ain_r       <= '0;
      aout_r      <= '0;
      off_r       <= '0;
      width_r     <= 32'd0;
      height_r    <= 32'd0;
      x_r         <= 32'd0;
      y_r         <= 32'd0;
      rd_cnt_r    <= 4'd0;
      cap_cnt_r   <= 4'd0;
      col_r       <= 2'd0;
      cap_pend_r  <= 1'b0;
      for (int i = 0; i < 9; i++) win_r[i] <= 8'd0;
      done_r      <= 1'b0;
      mem_rd_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else begin
      // Read data arrives the cycle after the strobe.
      cap_pend_r <= mem_rd_r;
      case (state_r)
        S_IDLE: begin
          mem_rd_r <= 1'b0;
          mem_wr_r <= 1'b0;
          if (start && !done_r) begin
            ain_r    <= addr_in;
            aout_r   <= addr_out;
            width_r  <= width;
            height_r <= height;
            x_r      <= 32'd0;
            y_r      <= 32'd0;
            off_r    <= '0;
            state_r  <= S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          if (empty_s) begin
            done_r  <= 1'b1;
            state_r <= S_DONE;
          end else if (border_s) begin
            mem_wr_r    <= 1'b1;
            mem_addr_r  <= aout_r + off_r;
            mem_wdata_r <= '0;
            state_r     <= S_WRITE;
          end else begin
            mem_rd_r   <= 1'b1;
            mem_addr_r <= rd_first_s;
            rd_cnt_r   <= 4'd0;
            col_r      <= 2'd0;
            cap_cnt_r  <= 4'd0;
            state_r    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (mem_rd_r) begin
            if (rd_cnt_r == 4'd8) begin
              mem_rd_r <= 1'b0;
            end else if (col_r == 2'd2) begin
              rd_cnt_r   <= rd_cnt_r + 4'd1;
              col_r      <= 2'd0;
              mem_addr_r <= mem_addr_r + wid_a_s - TWO_A;
            end else begin
              rd_cnt_r   <= rd_cnt_r + 4'd1;
              col_r      <= col_r + 2'd1;
              mem_addr_r <= mem_addr_r + ONE_A;
            end
          end
          if (cap_pend_r) begin
            for (int i = 0; i < 8; i++) win_r[i] <= win_r[i+1];
            win_r[8] <= gray_of(mem_rdata[23:0]);
            if (cap_cnt_r == 4'd8) begin
              state_r <= S_CALC;
            end else begin
              cap_cnt_r <= cap_cnt_r + 4'd1;
            end
          end
        end
        S_CALC: begin
          mem_wr_r    <= 1'b1;
          mem_addr_r  <= aout_r + off_r;
          mem_wdata_r <= DW'({8'h00, m_s, m_s, m_s});
          state_r     <= S_WRITE;
        end
        S_WRITE: begin
          mem_wr_r <= 1'b0;
          state_r  <= S_NEXT;
        end
        S_NEXT: begin
          off_r <= off_r + ONE_A;
          if (last_col_s) begin
            x_r <= 32'd0;
            if (last_row_s) begin
              done_r  <= 1'b1;
              state_r <= S_DONE;
            end else begin
              y_r     <= y_r + 32'd1;
              state_r <= S_DISPATCH;
            end
          end else begin
            x_r     <= x_r + 32'd1;
            state_r <= S_DISPATCH;
          end
        end
        S_DONE: begin
          mem_rd_r <= 1'b0;
          mem_wr_r <= 1'b0;
          if (!start) begin
            done_r  <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r  <= S_IDLE;
          done_r   <= 1'b0;
          mem_rd_r <= 1'b0;
          mem_wr_r <= 1'b0;
        end
      endcase
    end
  end

  assign done      = done_r;
  assign mem_rd    = mem_rd_r;
  assign mem_wr    = mem_wr_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_edge_detect.sv
// Directed bench for edge_detect: a word memory model feeds reads, observed
// writes are checked against a reference Sobel model through a scoreboard.
module tb_edge_detect;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] addr_in, addr_out;
  logic [31:0]   width, height;
  logic          start;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [DW-1:0] mem_rdata;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;

  logic [31:0] mem [0:4095];
  logic [31:0] dst [0:4095];
  logic [31:0] snap [0:15];
  logic [63:0] got_q [$];
  logic [63:0] exp_q [$];
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  int n_checks = 0, n_err = 0;
  int rd0, wr0;

  always #5 clk = ~clk;

  edge_detect #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n), .addr_in(addr_in), .addr_out(addr_out),
    .width(width), .height(height), .start(start), .done(done),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata)
  );

  // Memory model: registered read data, write capture into scoreboard queue.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr[11:0]];
    else        mem_rdata <= 32'hBAD0_BAD0;
    if (mem_wr) begin
      dst[mem_addr[11:0]] <= mem_wdata;
      got_q.push_back({mem_addr, mem_wdata});
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_rd) rd_cnt <= rd_cnt + 1;
    if (mem_rd && mem_wr) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int gray_ref(input logic [31:0] px);
    return (int'(px[23:16]) + 2 * int'(px[15:8]) + int'(px[7:0])) / 4;
  endfunction

  function automatic logic [31:0] expect_px(input int ain, input int w, input int h,
                                            input int x, input int y);
    int kxw [9];
    int kyw [9];
    int sx, sy, g, m, a;
    kxw = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    kyw = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    if (x == 0 || y == 0 || x == w - 1 || y == h - 1) return 32'h0;
    sx = 0;
    sy = 0;
    for (int i = 0; i < 9; i++) begin
      a = (ain + (y + i / 3 - 1) * w + (x + i % 3 - 1)) & 4095;
      g = gray_ref(mem[a]);
      sx += kxw[i] * g;
      sy += kyw[i] * g;
    end
    m = (sx < 0 ? -sx : sx) + (sy < 0 ? -sy : sy);
    if (m > 255) m = 255;
    return {8'h00, 8'(m), 8'(m), 8'(m)};
  endfunction

  task automatic push_expect(input int ain, input int aout, input int w, input int h);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        exp_q.push_back({32'(aout + y * w + x), expect_px(ain, w, h, x, y)});
  endtask

  task automatic drain(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++)
      check($sformatf("%s_wr%0d", tag, i), got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
  endtask

  task automatic run_job(input string tag, input int ain, input int aout,
                         input int w, input int h);
    addr_in  = 32'(ain);
    addr_out = 32'(aout);
    width    = 32'(w);
    height   = 32'(h);
    push_expect(ain, aout, w, h);
    start = 1'b1;
    wait_done(3000);
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic release_start(input string tag);
    start = 1'b0;
    @(negedge clk);
    check({tag, "_done_fall"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic seen;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    start = 1'b0; addr_in = '0; addr_out = '0; width = 32'd0; height = 32'd0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd", 64'(mem_rd), 64'd0);
    check("rst_wr", 64'(mem_wr), 64'd0);
    check("rst_addr_wdata", {mem_addr, mem_wdata}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Uniform 4x4: every gradient is zero.
    for (int i = 0; i < 16; i++) mem[i] = 32'h0080_8080;
    rd0 = rd_cnt;
    run_job("t1", 0, 100, 4, 4);
    drain("t1");
    check("t1_reads", 64'(rd_cnt - rd0), 64'd36);
    release_start("t1");

    // Vertical step to white: saturated centre.
    for (int i = 0; i < 9; i++) mem[200 + i] = (i % 3 == 2) ? 32'h00FF_FFFF : 32'h0;
    run_job("t2", 200, 300, 3, 3);
    drain("t2");
    check("t2_centre", 64'(dst[304]), 64'h00FF_FFFF);
    check("t2_corner", 64'(dst[300]), 64'h0);
    release_start("t2");

    // Faint right column: centre 0x40.
    for (int i = 0; i < 9; i++) mem[400 + i] = (i % 3 == 2) ? 32'h0010_1010 : 32'h0;
    run_job("t3", 400, 500, 3, 3);
    drain("t3");
    check("t3_centre", 64'(dst[504]), 64'h0040_4040);
    release_start("t3");

    // Random 5x4 image.
    for (int i = 0; i < 20; i++) mem[600 + i] = {8'h00, 24'($urandom)};
    rd0 = rd_cnt;
    run_job("t4", 600, 700, 5, 4);
    drain("t4");
    check("t4_reads", 64'(rd_cnt - rd0), 64'd54);
    release_start("t4");

    // Empty image: done quickly, no accesses.
    rd0 = rd_cnt; wr0 = wr_cnt;
    addr_in = 32'd0; addr_out = 32'd100; width = 32'd0; height = 32'd5;
    start = 1'b1;
    wait_done(3);
    check("t5_done", 64'(done), 64'd1);
    check("t5_no_access", {32'(rd_cnt - rd0), 32'(wr_cnt - wr0)}, 64'd0);
    release_start("t5");

    // Reset mid-LOAD of a large job, then a fresh small job with start held.
    for (int i = 0; i < 16; i++) mem[i] = {8'h00, 24'($urandom)};
    addr_in = 32'd8; addr_out = 32'd2048; width = 32'd640; height = 32'd480;
    start = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5000 && !seen; c++) begin
      @(negedge clk);
      if (mem_rd === 1'b1) seen = 1'b1;
    end
    check("t6_load_seen", 64'(seen), 64'd1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_strobes", {61'd0, done, mem_rd, mem_wr}, 64'd0);
    check("t6_rst_addr_wdata", {mem_addr, mem_wdata}, 64'd0);
    rd0 = rd_cnt; wr0 = wr_cnt;
    addr_in = 32'd0; addr_out = 32'd100; width = 32'd4; height = 32'd4;
    got_q.delete();
    push_expect(0, 100, 4, 4);
    @(negedge clk);
    check("t6_quiet_in_reset", {32'(rd_cnt - rd0), 32'(wr_cnt - wr0)}, 64'd0);
    reset_n = 1'b1;
    wait_done(3000);
    check("t6_done", 64'(done), 64'd1);
    drain("t6");

    // Start held after done: no new job.
    rd0 = rd_cnt; wr0 = wr_cnt;
    for (int c = 0; c < 10; c++) @(negedge clk);
    check("t7_done_held", 64'(done), 64'd1);
    check("t7_no_rerun", {32'(rd_cnt - rd0), 32'(wr_cnt - wr0)}, 64'd0);
    for (int i = 0; i < 16; i++) snap[i] = dst[100 + i];
    release_start("t7");
    run_job("t7b", 0, 100, 4, 4);
    drain("t7b");
    for (int i = 0; i < 16; i++)
      check($sformatf("t7_same%0d", i), 64'(dst[100 + i]), 64'(snap[i]));
    release_start("t7b");

    check("rd_wr_exclusive", 64'(both_cnt), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
